// File: rtl/unsigned_approx_mult_pipe_pkg.sv
// Shared constants and helpers for the unsigned approximate multiplier.
// Optional compensation term is enabled by the APPROX_COMP_EN macro.
package unsigned_approx_mult_pipe_pkg;

    localparam int DEF_W      = 32;
    localparam int DEF_L      = 10;
    localparam int DEF_STAGES = 2;

    typedef enum logic {
        MODE_APPROX = 1'b0,
        MODE_EXACT  = 1'b1
    } mode_e;

    function automatic int res_w(input int w);
        return 2 * w;
    endfunction

endpackage

// File: rtl/unsigned_approx_mult_pipe_comp.sv
// Compensation term for the truncated low partial products.
// Built only when APPROX_COMP_EN is defined.
module approx_comp_gen
    import unsigned_approx_mult_pipe_pkg::*;
#(
    parameter int W = DEF_W,
    parameter int L = DEF_L
)(
    input  logic [L-1:0]        x,
    input  logic [L-1:0]        y,
    output logic [res_w(W)-1:0] c
);

    localparam int ZW = res_w(W);
    localparam int CW = $clog2(L + 1);

    logic [CW-1:0] w_cnt;

    // Count set bits on the anti-diagonal of weight 2^(L-1).
    always_comb begin
        w_cnt = '0;
        for (int i = 0; i < L; i++) begin
            w_cnt = w_cnt + CW'(x[i] & y[L-1-i]);
        end
    end

    assign c = ZW'(w_cnt) << (L - 1);

endmodule

// File: rtl/unsigned_approx_mult_pipe.sv
// Pipelined unsigned multiplier with per-transaction exact/approx mode.
// Define APPROX_COMP_EN to add the low-part compensation term.
module unsigned_approx_mult_pipe
    import unsigned_approx_mult_pipe_pkg::*;
#(
    parameter int W      = DEF_W,
    parameter int L      = DEF_L,
    parameter int STAGES = DEF_STAGES
)(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [W-1:0]        x,
    input  logic [W-1:0]        y,
    input  logic                exact,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [res_w(W)-1:0] z,
    output logic                out_exact
);

    localparam int ZW = res_w(W);

    logic [ZW-1:0] w_xw;
    logic [ZW-1:0] w_yw;
    logic [ZW-1:0] w_xh;
    logic [ZW-1:0] w_full;
    logic [ZW-1:0] w_trunc;
    logic [ZW-1:0] w_c;
    logic [ZW-1:0] w_approx;
    logic [ZW-1:0] w_prod;

    logic [STAGES-1:0] r_v;
    logic [STAGES-1:0] r_ex;
    logic [ZW-1:0]     r_z [STAGES];
    logic [STAGES-1:0] w_ld;

    assign w_xw = ZW'(x);
    assign w_yw = ZW'(y);
    assign w_xh = ZW'(x >> L);

    assign w_full  = w_xw * w_yw;
    assign w_trunc = (w_yw * w_xh) << L;

`ifdef APPROX_COMP_EN
    approx_comp_gen #(
        .W (W),
        .L (L)
    ) u_comp (
        .x (x[L-1:0]),
        .y (y[L-1:0]),
        .c (w_c)
    );
`else
    assign w_c = '0;
`endif

    assign w_approx = w_trunc + w_c;
    assign w_prod   = (mode_e'(exact) == MODE_EXACT) ? w_full : w_approx;

    // A stage loads if it or any stage below it is empty, or the sink takes.
    always_comb begin : p_ld
        logic w_go;
        w_ld = '0;
        w_go = out_ready;
        for (int i = STAGES - 1; i >= 0; i--) begin
            w_go    = w_go | ~r_v[i];
            w_ld[i] = w_go;
        end
    end

    // Stage 0 captures the product; later stages only retime it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v  <= '0;
            r_ex <= '0;
            for (int i = 0; i < STAGES; i++) begin
                r_z[i] <= '0;
            end
        end else begin
            if (w_ld[0]) begin
                r_v[0] <= in_valid;
                if (in_valid) begin
                    r_z[0]  <= w_prod;
                    r_ex[0] <= exact;
                end
            end
            for (int i = 1; i < STAGES; i++) begin
                if (w_ld[i]) begin
                    r_v[i] <= r_v[i-1];
                    if (r_v[i-1]) begin
                        r_z[i]  <= r_z[i-1];
                        r_ex[i] <= r_ex[i-1];
                    end
                end
            end
        end
    end

    assign in_ready  = w_ld[0];
    assign out_valid = r_v[STAGES-1];
    assign z         = r_z[STAGES-1];
    assign out_exact = r_ex[STAGES-1];

endmodule

// File: tb/tb_unsigned_approx_mult_pipe.sv
// Directed bench for unsigned_approx_mult_pipe (W=32, L=10, STAGES=2).
// Expectations follow APPROX_COMP_EN when it is defined for the build.
module tb_unsigned_approx_mult_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] x;
    logic [31:0] y;
    logic        exact;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] z;
    logic        out_exact;

    int total = 0;
    int bad   = 0;

`ifdef APPROX_COMP_EN
    localparam logic [63:0] E36 = 64'h1400;
    localparam logic [63:0] E201 = 64'h400;
    localparam logic [63:0] EFF = 64'hFFFFFBFF_00001800;
`else
    localparam logic [63:0] E36 = 64'h0;
    localparam logic [63:0] E201 = 64'h0;
    localparam logic [63:0] EFF = 64'hFFFFFBFF_00000400;
`endif

    always #5 clk = ~clk;

    unsigned_approx_mult_pipe dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .exact     (exact),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .z         (z),
        .out_exact (out_exact)
    );

    function automatic logic [63:0] model(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic ex);
        logic [63:0] p;
        int n;
        n = 0;
        if (ex) return {32'b0, a} * {32'b0, b};
        p = {32'b0, a & 32'hFFFF_FC00} * {32'b0, b};
`ifdef APPROX_COMP_EN
        for (int i = 0; i < 10; i++) begin
            if (a[i] && b[9-i]) n++;
        end
`endif
        return p + (64'(n) << 9);
    endfunction

    task automatic run_one(input logic [31:0] a, input logic [31:0] b,
                           input logic ex, output logic [63:0] rz,
                           output logic re, output int lat,
                           output logic acc);
        @(negedge clk);
        in_valid  = 1'b1;
        x         = a;
        y         = b;
        exact     = ex;
        out_ready = 1'b1;
        #1 acc = in_ready;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        rz = z;
        re = out_exact;
    endtask

    task automatic test_reset;
        rst_n = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        x = '0;
        y = '0;
        exact = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_out_valid: got %b want 0", out_valid);
        end
        total++;
        if (z !== 64'h0) begin
            bad++;
            $display("FAIL reset_z: got %h want 0", z);
        end
        total++;
        if (out_exact !== 1'b0) begin
            bad++;
            $display("FAIL reset_out_exact: got %b want 0", out_exact);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle_valid: got %b want 0", out_valid);
        end
    endtask

    task automatic test_approx;
        logic [63:0] rz;
        logic re;
        logic acc;
        int lat;
        run_one(32'h400, 32'd5, 1'b0, rz, re, lat, acc);
        total++;
        if (acc !== 1'b1) begin
            bad++;
            $display("FAIL approx_accept: got %b want 1", acc);
        end
        total++;
        if (lat != 2) begin
            bad++;
            $display("FAIL approx_latency: got %0d want 2", lat);
        end
        total++;
        if (rz !== 64'h1400) begin
            bad++;
            $display("FAIL approx_400x5: got %h want 1400", rz);
        end
        total++;
        if (re !== 1'b0) begin
            bad++;
            $display("FAIL approx_mode_bit: got %b want 0", re);
        end
        run_one(32'h3FF, 32'h3FF, 1'b0, rz, re, lat, acc);
        total++;
        if (rz !== E36) begin
            bad++;
            $display("FAIL approx_3ff: got %h want %h", rz, E36);
        end
        run_one(32'h201, 32'h201, 1'b0, rz, re, lat, acc);
        total++;
        if (rz !== E201) begin
            bad++;
            $display("FAIL approx_201: got %h want %h", rz, E201);
        end
        run_one(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, rz, re, lat, acc);
        total++;
        if (rz !== EFF) begin
            bad++;
            $display("FAIL approx_max: got %h want %h", rz, EFF);
        end
    endtask

    task automatic test_exact;
        logic [63:0] rz;
        logic re;
        logic acc;
        int lat;
        run_one(32'h3FF, 32'h3FF, 1'b1, rz, re, lat, acc);
        total++;
        if (rz !== 64'hFF801) begin
            bad++;
            $display("FAIL exact_3ff: got %h want ff801", rz);
        end
        total++;
        if (re !== 1'b1) begin
            bad++;
            $display("FAIL exact_mode_bit: got %b want 1", re);
        end
        run_one(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, rz, re, lat, acc);
        total++;
        if (rz !== 64'hFFFFFFFE_00000001) begin
            bad++;
            $display("FAIL exact_max: got %h want fffffffe00000001", rz);
        end
        run_one(32'h0, 32'hDEAD_BEEF, 1'b1, rz, re, lat, acc);
        total++;
        if (rz !== 64'h0) begin
            bad++;
            $display("FAIL exact_zero: got %h want 0", rz);
        end
    endtask

    task automatic test_backpressure;
        logic [31:0] va [3];
        logic [31:0] vb [3];
        logic [63:0] want [3];
        logic [63:0] got [$];
        int acc;
        va   = '{32'd3, 32'd7, 32'h10000};
        vb   = '{32'd5, 32'd11, 32'h10000};
        want = '{64'd15, 64'd77, 64'h1_0000_0000};
        acc  = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            out_ready = 1'b0;
            in_valid  = 1'b1;
            exact     = 1'b1;
            x         = va[k];
            y         = vb[k];
            #1 if (in_ready) acc++;
        end
        total++;
        if (acc != 2) begin
            bad++;
            $display("FAIL bp_accepted: got %0d want 2", acc);
        end
        @(negedge clk);
        total++;
        if (in_ready !== 1'b0) begin
            bad++;
            $display("FAIL bp_in_ready: got %b want 0", in_ready);
        end
        repeat (2) @(negedge clk);
        total++;
        if (out_valid !== 1'b1 || z !== want[0]) begin
            bad++;
            $display("FAIL bp_hold: got v=%b z=%h want v=1 z=%h",
                     out_valid, z, want[0]);
        end
        out_ready = 1'b1;
        for (int n = 0; n < 8; n++) begin
            if (out_valid) got.push_back(z);
            @(negedge clk);
            in_valid = 1'b0;
        end
        total++;
        if (got.size() != 3) begin
            bad++;
            $display("FAIL bp_count: got %0d want 3", got.size());
        end
        for (int k = 0; k < 3; k++) begin
            total++;
            if (k >= got.size()) begin
                bad++;
                $display("FAIL bp_order%0d: got none want %h", k, want[k]);
            end else if (got[k] !== want[k]) begin
                bad++;
                $display("FAIL bp_order%0d: got %h want %h",
                         k, got[k], want[k]);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [64:0] q [$];
        logic [64:0] w;
        logic [31:0] a;
        logic [31:0] b;
        logic e;
        int nres;
        int first;
        int last;
        int stall;
        nres = 0;
        first = -1;
        last = -1;
        stall = 0;
        out_ready = 1'b1;
        for (int n = 0; n < 110; n++) begin
            @(negedge clk);
            if (out_valid) begin
                total++;
                if (q.size() == 0) begin
                    bad++;
                    $display("FAIL b2b_extra: got %h want none", z);
                end else begin
                    w = q.pop_front();
                    if ({out_exact, z} !== w) begin
                        bad++;
                        $display("FAIL b2b_result: got %b/%h want %b/%h",
                                 out_exact, z, w[64], w[63:0]);
                    end
                end
                nres++;
                if (first < 0) first = n;
                last = n;
            end
            if (n < 100) begin
                a = $urandom;
                b = $urandom;
                e = 1'($urandom_range(0, 1));
                in_valid = 1'b1;
                x = a;
                y = b;
                exact = e;
                #1;
                if (in_ready) q.push_back({e, model(a, b, e)});
                else stall++;
            end else begin
                in_valid = 1'b0;
            end
        end
        total++;
        if (stall != 0) begin
            bad++;
            $display("FAIL b2b_stall: got %0d want 0", stall);
        end
        total++;
        if (nres != 100) begin
            bad++;
            $display("FAIL b2b_count: got %0d want 100", nres);
        end
        total++;
        if (last - first != 99) begin
            bad++;
            $display("FAIL b2b_rate: got span %0d want 99", last - first);
        end
    endtask

    task automatic test_mid_reset;
        logic [63:0] rz;
        logic re;
        logic acc;
        int lat;
        int stale;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            exact = 1'b1;
            x = 32'd100 + 32'(k);
            y = 32'd3;
        end
        total++;
        if (out_valid !== 1'b1) begin
            bad++;
            $display("FAIL mr_pre_valid: got %b want 1", out_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0 || z !== 64'h0 || out_exact !== 1'b0) begin
            bad++;
            $display("FAIL mr_clear: got v=%b z=%h e=%b want 0/0/0",
                     out_valid, z, out_exact);
        end
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        stale = 0;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        total++;
        if (stale != 0) begin
            bad++;
            $display("FAIL mr_stale: got %0d want 0", stale);
        end
        run_one(32'd9, 32'd9, 1'b1, rz, re, lat, acc);
        total++;
        if (rz !== 64'd81 || lat != 2) begin
            bad++;
            $display("FAIL mr_after: got z=%h lat=%0d want 51/2", rz, lat);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_approx();
        test_exact();
        test_backpressure();
        test_back_to_back();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/unsigned_approx_mult_pipe.md
UNSIGNED_APPROX_MULT_PIPE -- requirements
Module: unsigned_approx_mult_pipe

Interface
REQ-001 SHALL have parameter W, default 32: operand width in bits (legal range 8..64).
REQ-002 SHALL have parameter L, default 10: truncated low bits of x (legal range 1..W-2).
REQ-003 SHALL have parameter STAGES, default 2: pipeline register stages (legal range 1..4).
REQ-004 SHALL have port clk  in  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port in_valid  in  1  operand pair present.
REQ-007 SHALL have port in_ready  out  1  block accepts operands this cycle.
REQ-008 SHALL have port x  in  W  unsigned multiplier operand.
REQ-009 SHALL have port y  in  W  unsigned multiplicand operand.
REQ-010 SHALL have port exact  in  1  per-transaction mode; 1 = exact product, 0 = approximate.
REQ-011 SHALL have port out_valid  out  1  result present.
REQ-012 SHALL have port out_ready  in  1  consumer accepts result.
REQ-013 SHALL have port z  out  2W  unsigned product.
REQ-014 SHALL have port out_exact  out  1  mode bit travelling with z.

Function
REQ-015 Input transfer SHALL occur when in_valid and in_ready are both 1; output transfer SHALL occur when out_valid and out_ready are both 1.
REQ-016 Exact mode SHALL produce z = x*y, full 2W bits, no truncation.
REQ-017 Approximate mode SHALL produce z = ((y * x[W-1:L]) << L) + C, modulo 2^(2W).
REQ-018 C SHALL equal (number of pairs i+j = L-1, i,j < L, with x[i] & y[j] = 1) << (L-1).
REQ-019 Latency SHALL be exactly STAGES cycles from input transfer to out_valid, with no stall in between.
REQ-020 Each stage SHALL load when it is empty or its downstream stage transfers in the same cycle; the last stage's downstream is out_ready.
REQ-021 in_ready SHALL equal the stage-0 load condition (combinational, no in_valid dependency).
REQ-022 Under out_ready = 0, z, out_exact and out_valid SHALL hold stable until transfer.
REQ-023 Simultaneous input and output transfer in a full pipeline SHALL sustain 1 result per cycle.
REQ-024 No transaction SHALL be dropped, duplicated or reordered.
REQ-025 z and out_exact SHALL be unconstrained (don't-care) while out_valid = 0.

Reset
REQ-026 rst_n low SHALL clear all stage-valid flags, out_valid, z and out_exact to 0, with no clock required.
REQ-027 Reset during operation SHALL discard all in-flight transactions.
REQ-028 in_ready SHALL be 1 from the first cycle after rst_n deasserts.

Configuration
REQ-029 With macro APPROX_COMP_EN defined, C SHALL be computed and added as in REQ-018.
REQ-030 Without APPROX_COMP_EN, C SHALL be 0 and no compensation logic SHALL be synthesised.
REQ-031 The exact-mode result SHALL be identical with and without the macro.

Structure
REQ-032 A shared package SHALL hold the default W/L/STAGES constants and the result-width function 2*W.
REQ-033 The C computation SHALL live in one sub-module, approx_comp_gen (inputs x[L-1:0], y[L-1:0]; output C), instantiated only under APPROX_COMP_EN.
REQ-034 The product SHALL be computed in stage 0; the remaining stages SHALL be pure retiming registers.

Verification (W=32, L=10, STAGES=2)
REQ-035 x=0x400, y=5, exact=0 -> z=0x1400 two cycles later (low bits zero, so no approximation error).
REQ-036 x=0x3FF, y=0x3FF, exact=0 -> z=0x1400 with APPROX_COMP_EN, z=0 without it.
REQ-037 x=0x3FF, y=0x3FF, exact=1 -> z=0xFF801, out_exact=1, in both builds.
REQ-038 Hold out_ready=0 and stream 3 inputs -> in_ready falls after 2 accepted; z holds first result; releasing out_ready drains all 3 results in order.
REQ-039 Continuous in_valid and out_ready for 100 random pairs -> 1 result/cycle, all matching the REQ-016/017 model.
REQ-040 Assert rst_n low mid-stream -> out_valid=0 immediately; after release, no stale results appear.
